// File: rtl/dram_request_issuer_pkg.sv
// Shared types and address-field defaults for the DRAM request issuer.
// Holds the command encoding, the FSM state type and the field-width defaults.
package dram_request_issuer_pkg;

  typedef enum logic [2:0] {
    CmdNop = 3'd0,
    CmdAct = 3'd1,
    CmdPre = 3'd2,
    CmdRd  = 3'd3,
    CmdWr  = 3'd4
  } dram_cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StPreWait,
    StAct,
    StActWait,
    StIssue,
    StData,
    StDone
  } issuer_state_t;

  localparam int unsigned DefWordW = 32;
  localparam int unsigned DefColW  = 10;
  localparam int unsigned DefBankW = 2;
  localparam int unsigned DefRowW  = 15;
  // Column field starts above the ignored byte-offset bits.
  localparam int unsigned ColLsb   = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dram_request_issuer_if.sv
// Scheduler-to-issuer request channel: current request, look-ahead request and
// completion callback.
interface dram_request_issuer_if #(
  parameter int unsigned WORD_W = 32
);
  logic              ramREN_curr;
  logic              ramWEN_curr;
  logic [WORD_W-1:0] ramaddr_rq;
  logic [WORD_W-1:0] ramstore_rq;
  logic              ramREN_ftrt;
  logic              ramWEN_ftrt;
  logic [WORD_W-1:0] ramaddr_rq_ft;
  logic [WORD_W-1:0] ramstore_rq_ft;
  logic              request_done;
  logic [WORD_W-1:0] memaddr_callback;

  modport master (
    output ramREN_curr, ramWEN_curr, ramaddr_rq, ramstore_rq,
    output ramREN_ftrt, ramWEN_ftrt, ramaddr_rq_ft, ramstore_rq_ft,
    input  request_done, memaddr_callback
  );

  modport slave (
    input  ramREN_curr, ramWEN_curr, ramaddr_rq, ramstore_rq,
    input  ramREN_ftrt, ramWEN_ftrt, ramaddr_rq_ft, ramstore_rq_ft,
    output request_done, memaddr_callback
  );
endinterface

// File: rtl/dram_request_issuer_row_tracker.sv
// Per-bank open-row table: one valid bit and row address per bank, with a
// combinational hit/conflict lookup against the registered table.
module dram_request_issuer_row_tracker #(
  parameter int unsigned BANK_W = 2,
  parameter int unsigned ROW_W  = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [BANK_W-1:0] lookup_bank_i,
  input  logic [ROW_W-1:0]  lookup_row_i,
  output logic              hit_o,
  output logic              conflict_o,
  input  logic              set_i,
  input  logic [BANK_W-1:0] set_bank_i,
  input  logic [ROW_W-1:0]  set_row_i,
  input  logic              clr_i,
  input  logic [BANK_W-1:0] clr_bank_i,
  input  logic              clr_all_i
);
  localparam int unsigned Banks = 2 ** BANK_W;

  logic [Banks-1:0]            valid_q, valid_d;
  logic [Banks-1:0][ROW_W-1:0] row_q, row_d;

  always_comb begin
    valid_d = valid_q;
    row_d   = row_q;
    if (clr_all_i) begin
      valid_d = '0;
    end else begin
      if (clr_i) valid_d[clr_bank_i] = 1'b0;
      if (set_i) begin
        valid_d[set_bank_i] = 1'b1;
        row_d[set_bank_i]   = set_row_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      row_q   <= '0;
    end else begin
      valid_q <= valid_d;
      row_q   <= row_d;
    end
  end

  assign hit_o      = valid_q[lookup_bank_i] && (row_q[lookup_bank_i] == lookup_row_i);
  assign conflict_o = valid_q[lookup_bank_i] && (row_q[lookup_bank_i] != lookup_row_i);

endmodule

// File: rtl/dram_request_issuer.sv
// Open-page DRAM command issuer: turns scheduler requests into PRE/ACT/RD/WR
// sequences and uses the look-ahead request to close pages early.
module dram_request_issuer
  import dram_request_issuer_pkg::*;
#(
  parameter int unsigned WORD_W = DefWordW,
  parameter int unsigned COL_W  = DefColW,
  parameter int unsigned BANK_W = DefBankW,
  parameter int unsigned ROW_W  = DefRowW,
  parameter int unsigned T_RCD  = 3,
  parameter int unsigned T_RP   = 3,
  parameter int unsigned T_CL   = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  dram_request_issuer_if.slave  sched_io,
  output dram_cmd_t             cmd,
  output logic [BANK_W-1:0]     cmd_bank,
  output logic [ROW_W-1:0]      cmd_row,
  output logic [COL_W-1:0]      cmd_col,
  output logic [WORD_W-1:0]     wdata
);
  localparam int unsigned TimerW = $clog2(max3(T_RCD, T_RP, T_CL)) + 1;
  localparam int unsigned BankLo = ColLsb + COL_W;
  localparam int unsigned RowLo  = BankLo + BANK_W;

  issuer_state_t      state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               we_q, we_d;
  logic [WORD_W-1:0]  addr_q, addr_d, data_q, data_d;
  dram_cmd_t          cmd_q, cmd_d;
  logic [BANK_W-1:0]  bank_q, bank_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic               done_q, done_d;
  logic [WORD_W-1:0]  cb_q, cb_d;

  logic      req_valid, ft_valid, close_page, trk_hit, trk_conflict, unused_ft;
  dram_cmd_t issue_cmd;

  assign req_valid = sched_io.ramREN_curr | sched_io.ramWEN_curr;
  assign ft_valid  = sched_io.ramREN_ftrt | sched_io.ramWEN_ftrt;
  assign issue_cmd = we_q ? CmdWr : CmdRd;
  // Look-ahead targets another row of the bank just used: precharge it now.
  assign close_page = ft_valid &&
      (sched_io.ramaddr_rq_ft[BankLo +: BANK_W] == addr_q[BankLo +: BANK_W]) &&
      (sched_io.ramaddr_rq_ft[RowLo +: ROW_W] != addr_q[RowLo +: ROW_W]);
  assign unused_ft = ^sched_io.ramstore_rq_ft;

  dram_request_issuer_row_tracker #(
    .BANK_W(BANK_W),
    .ROW_W (ROW_W)
  ) u_row_tracker (
    .clk_i        (CLK),
    .rst_ni       (nRST),
    .lookup_bank_i(sched_io.ramaddr_rq[BankLo +: BANK_W]),
    .lookup_row_i (sched_io.ramaddr_rq[RowLo +: ROW_W]),
    .hit_o        (trk_hit),
    .conflict_o   (trk_conflict),
    .set_i        (cmd_d == CmdAct),
    .set_bank_i   (bank_d),
    .set_row_i    (row_d),
    .clr_i        (cmd_d == CmdPre),
    .clr_bank_i   (bank_d),
    .clr_all_i    (1'b0)
  );

  // cmd_d is the command of the state being entered, so it lands on cmd in that state.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cmd_d   = CmdNop;
    done_d  = 1'b0;
    cb_d    = cb_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d   = sched_io.ramWEN_curr;
          addr_d = sched_io.ramaddr_rq;
          data_d = sched_io.ramstore_rq;
          if (trk_hit) begin
            state_d = StIssue;
            cmd_d   = sched_io.ramWEN_curr ? CmdWr : CmdRd;
          end else if (trk_conflict) begin
            state_d = StPre;
            cmd_d   = CmdPre;
          end else begin
            state_d = StAct;
            cmd_d   = CmdAct;
          end
        end
      end
      StPre: begin
        if (T_RP > 1) begin
          state_d = StPreWait;
          timer_d = TimerW'(T_RP - 2);
        end else begin
          state_d = StAct;
          cmd_d   = CmdAct;
        end
      end
      StPreWait: begin
        if (timer_q == '0) begin
          state_d = StAct;
          cmd_d   = CmdAct;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StAct: begin
        if (T_RCD > 1) begin
          state_d = StActWait;
          timer_d = TimerW'(T_RCD - 2);
        end else begin
          state_d = StIssue;
          cmd_d   = issue_cmd;
        end
      end
      StActWait: begin
        if (timer_q == '0) begin
          state_d = StIssue;
          cmd_d   = issue_cmd;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StIssue: begin
        state_d = StData;
        timer_d = TimerW'(T_CL - 1);
      end
      StData: begin
        if (timer_q == '0) begin
          state_d = StDone;
          done_d  = 1'b1;
          cb_d    = addr_q;
          if (close_page) cmd_d = CmdPre;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    wdata_d = wdata_q;
    if (cmd_d != CmdNop) bank_d = addr_d[BankLo +: BANK_W];
    if (cmd_d == CmdAct) row_d = addr_d[RowLo +: ROW_W];
    if (cmd_d == CmdRd || cmd_d == CmdWr) col_d = addr_d[ColLsb +: COL_W];
    if (cmd_d == CmdWr) wdata_d = data_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      timer_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cmd_q   <= CmdNop;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      cb_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      cb_q    <= cb_d;
    end
  end

  assign cmd                       = cmd_q;
  assign cmd_bank                  = bank_q;
  assign cmd_row                   = row_q;
  assign cmd_col                   = col_q;
  assign wdata                     = wdata_q;
  assign sched_io.request_done     = done_q;
  assign sched_io.memaddr_callback = cb_q;

endmodule

// File: tb/tb_dram_request_issuer.sv
// Self-checking bench for dram_request_issuer: directed scenarios plus random
// traffic against an open-page model that predicts per-cycle commands.
module tb_dram_request_issuer;
  import dram_request_issuer_pkg::*;

  localparam int unsigned T_RCD = 3;
  localparam int unsigned T_RP  = 3;
  localparam int unsigned T_CL  = 4;

  logic        clk  = 1'b0;
  logic        nrst = 1'b0;
  dram_cmd_t   cmd;
  logic [1:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [31:0] wdata;

  int errors = 0;
  int checks = 0;

  // Model of which row each bank holds open.
  bit open_v [4];
  int open_r [4];

  dram_request_issuer_if #(.WORD_W(32)) sif ();

  dram_request_issuer #(
    .WORD_W(32), .COL_W(10), .BANK_W(2), .ROW_W(15),
    .T_RCD (T_RCD), .T_RP(T_RP), .T_CL(T_CL)
  ) dut (
    .CLK     (clk),
    .nRST    (nrst),
    .sched_io(sif),
    .cmd     (cmd),
    .cmd_bank(cmd_bank),
    .cmd_row (cmd_row),
    .cmd_col (cmd_col),
    .wdata   (wdata)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    sif.ramREN_curr    = 1'b0;
    sif.ramWEN_curr    = 1'b0;
    sif.ramaddr_rq     = '0;
    sif.ramstore_rq    = '0;
    sif.ramREN_ftrt    = 1'b0;
    sif.ramWEN_ftrt    = 1'b0;
    sif.ramaddr_rq_ft  = '0;
    sif.ramstore_rq_ft = '0;
  endtask

  function automatic logic [31:0] mk_addr(input int bank, input int row, input int col);
    return (32'(row) << 14) | (32'(bank) << 12) | (32'(col) << 2) |
           32'($urandom_range(0, 3)) | (32'($urandom_range(0, 7)) << 29);
  endfunction

  // Drive one request and compare every cycle until one cycle past completion.
  task automatic run_req(input string name, input logic [31:0] a, input logic [31:0] d,
                         input bit rd, input bit wr, input bit ftv, input logic [31:0] fa);
    int bank, row, col, fbank, frow;
    int t_pre, t_act, t_io, t_done;
    bit pre_close;
    dram_cmd_t io_cmd, exp;
    bank  = int'((a >> 12) & 32'h3);
    row   = int'((a >> 14) & 32'h7fff);
    col   = int'((a >> 2) & 32'h3ff);
    fbank = int'((fa >> 12) & 32'h3);
    frow  = int'((fa >> 14) & 32'h7fff);
    t_pre = -1;
    t_act = -1;
    if (open_v[bank] && open_r[bank] == row) begin
      t_io = 1;
    end else if (open_v[bank]) begin
      t_pre = 1;
      t_act = 1 + T_RP;
      t_io  = t_act + T_RCD;
    end else begin
      t_act = 1;
      t_io  = 1 + T_RCD;
    end
    t_done    = t_io + T_CL + 1;
    io_cmd    = wr ? CmdWr : CmdRd;
    pre_close = ftv && fbank == bank && frow != row;

    @(posedge clk);
    #1;
    sif.ramREN_curr   = rd;
    sif.ramWEN_curr   = wr;
    sif.ramaddr_rq    = a;
    sif.ramstore_rq   = d;
    sif.ramREN_ftrt   = ftv;
    sif.ramWEN_ftrt   = 1'b0;
    sif.ramaddr_rq_ft = fa;
    for (int off = 0; off <= t_done + 1; off++) begin
      @(negedge clk);
      exp = CmdNop;
      if (off == t_pre) exp = CmdPre;
      if (off == t_act) exp = CmdAct;
      if (off == t_io) exp = io_cmd;
      if (off == t_done && pre_close) exp = CmdPre;
      checks++;
      if (cmd !== exp) begin
        errors++;
        $display("FAIL %s cmd@%0d got=%0d exp=%0d", name, off, cmd, exp);
      end
      checks++;
      if (sif.request_done !== (off == t_done)) begin
        errors++;
        $display("FAIL %s done@%0d got=%b exp=%b", name, off, sif.request_done, off == t_done);
      end
      if (exp != CmdNop) begin
        checks++;
        if (cmd_bank !== 2'(bank)) begin
          errors++;
          $display("FAIL %s bank@%0d got=%0d exp=%0d", name, off, cmd_bank, bank);
        end
      end
      if (exp == CmdAct) begin
        checks++;
        if (cmd_row !== 15'(row)) begin
          errors++;
          $display("FAIL %s row@%0d got=%h exp=%h", name, off, cmd_row, row);
        end
      end
      if (off == t_io) begin
        checks++;
        if (cmd_col !== 10'(col)) begin
          errors++;
          $display("FAIL %s col got=%h exp=%h", name, cmd_col, col);
        end
        if (wr) begin
          checks++;
          if (wdata !== d) begin
            errors++;
            $display("FAIL %s wdata got=%h exp=%h", name, wdata, d);
          end
        end
      end
      if (off == t_done) begin
        checks++;
        if (sif.memaddr_callback !== a) begin
          errors++;
          $display("FAIL %s callback got=%h exp=%h", name, sif.memaddr_callback, a);
        end
        idle_inputs();
      end
    end
    open_v[bank] = !pre_close;
    open_r[bank] = row;
  endtask

  task automatic test_reset();
    idle_inputs();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (cmd !== CmdNop) begin errors++; $display("FAIL reset cmd got=%0d exp=0", cmd); end
    if (sif.request_done !== 1'b0) begin
      errors++; $display("FAIL reset done got=%b exp=0", sif.request_done);
    end
    if (sif.memaddr_callback !== 32'h0) begin
      errors++; $display("FAIL reset callback got=%h exp=0", sif.memaddr_callback);
    end
    if (cmd_bank !== 2'h0 || cmd_row !== 15'h0) begin
      errors++; $display("FAIL reset bank/row got=%h/%h exp=0/0", cmd_bank, cmd_row);
    end
    if (cmd_col !== 10'h0) begin errors++; $display("FAIL reset col got=%h exp=0", cmd_col); end
    if (wdata !== 32'h0) begin errors++; $display("FAIL reset wdata got=%h exp=0", wdata); end
    nrst = 1'b1;
    for (int b = 0; b < 4; b++) open_v[b] = 1'b0;
  endtask

  task automatic test_cold_read();
    run_req("cold_read", 32'h0000_1000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_row_hit();
    run_req("row_hit", 32'h0000_1004, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_write_conflict();
    run_req("write_conflict", 32'h0010_1000, 32'hdead_beef, 1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_close_page();
    run_req("close_page", 32'h0000_1000, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0010_1000);
    run_req("reopen", 32'h0000_1000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_both_high();
    run_req("both_high", 32'h0000_1008, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    @(posedge clk);
    #1;
    sif.ramREN_curr = 1'b1;
    sif.ramaddr_rq  = 32'h0020_2000;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      checks++;
      if (sif.request_done !== 1'b0) begin
        errors++; $display("FAIL reset_mid early done got=%b exp=0", sif.request_done);
      end
      if (cmd === CmdAct) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL reset_mid act got=none exp=ACT"); end
    @(negedge clk);
    nrst = 1'b0;
    #1;
    checks += 2;
    if (cmd !== CmdNop) begin errors++; $display("FAIL reset_mid cmd got=%0d exp=0", cmd); end
    if (sif.request_done !== 1'b0) begin
      errors++; $display("FAIL reset_mid done got=%b exp=0", sif.request_done);
    end
    idle_inputs();
    @(negedge clk);
    nrst = 1'b1;
    for (int b = 0; b < 4; b++) open_v[b] = 1'b0;
    run_req("reissue", 32'h0020_2000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] a, fa;
    bit rd, wr, ftv;
    for (int n = 0; n < 40; n++) begin
      a   = mk_addr($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 1023));
      fa  = mk_addr($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 1023));
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      ftv = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      run_req("random", a, $urandom, rd, wr, ftv, fa);
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_row_hit();
    test_write_conflict();
    test_close_page();
    test_both_high();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
